// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the 5-stage pipeline.
//
// Owns the PC register and drives a synchronous instruction memory. The
// current PC goes out to an external PC+4 adder and its sum comes back as
// the sequential next PC. Fetched instructions are registered into the
// IF/ID handoff, which uses a valid/ready handshake. A one-entry skid buffer
// catches the response that is already in flight when decode stalls. A taken
// branch or jump from EX redirects the PC and flushes the stage.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   pc             out  current fetch PC (lhs of the PC+4 adder)
//   seq_pc         in   adder result, pc+4
//   imem_en        out  fetch issue strobe
//   imem_addr      out  fetch address (equals pc)
//   imem_rdata     in   instruction, valid one cycle after an imem_en cycle
//   redirect_valid in   branch/jump taken from EX
//   redirect_pc    in   redirect target (low two bits ignored)
//   id_ready       in   decode accepts IF/ID this cycle
//   if_valid       out  IF/ID holds an instruction
//   if_pc          out  PC of that instruction
//   if_instr       out  the instruction
//
// Optional feature (macro IF_PERF_CNT_EN):
//   perf_fetch_cnt out  accepted handshakes
//   perf_stall_cnt out  cycles with if_valid && !id_ready
//   perf_flush_cnt out  redirect cycles
//   All three saturate at 32'hFFFF_FFFF and do not affect the datapath.

module if_fetch_stage #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] seq_pc,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic            skid_full_q, skid_full_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;

    logic            out_free;
    logic            issue;

    // Word-aligned targets only; the two low bits are dropped on purpose.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // The output register can take new data if it is empty or being consumed.
    assign out_free = !out_valid_q || id_ready;

    // Never issue unless the response is guaranteed a slot next cycle: with
    // the skid full there is no room, and with a response already in flight
    // into a stalled output register that response will claim the skid.
    assign issue = !redirect_valid && !skid_full_q && !(inflight_q && !out_free);

    assign pc        = pc_q;
    assign imem_en   = issue;
    assign imem_addr = pc_q;
    assign if_valid  = out_valid_q;
    assign if_pc     = out_pc_q;
    assign if_instr  = out_instr_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_instr_d   = out_instr_q;
        skid_full_d   = skid_full_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;

        if (redirect_valid) begin
            // Flush: the in-flight response is dropped by leaving inflight_d
            // low, and any transfer happening this cycle still completes.
            pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d          = seq_pc;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end

            if (inflight_q) begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    if (skid_full_q) begin
                        // Older skid entry goes first to keep issue order.
                        out_pc_d     = skid_pc_q;
                        out_instr_d  = skid_instr_q;
                        skid_pc_d    = inflight_pc_q;
                        skid_instr_d = imem_rdata;
                    end else begin
                        out_pc_d    = inflight_pc_q;
                        out_instr_d = imem_rdata;
                    end
                end else begin
                    skid_full_d  = 1'b1;
                    skid_pc_d    = inflight_pc_q;
                    skid_instr_d = imem_rdata;
                end
            end else if (out_free) begin
                if (skid_full_q) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = skid_pc_q;
                    out_instr_d = skid_instr_q;
                    skid_full_d = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_instr_q   <= NOP_INSTR;
            skid_full_q   <= 1'b0;
            skid_pc_q     <= '0;
            skid_instr_q  <= NOP_INSTR;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_instr_q   <= out_instr_d;
            skid_full_q   <= skid_full_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid_q && id_ready) begin
                fetch_cnt_q <= sat_inc(fetch_cnt_q);
            end
            if (out_valid_q && !id_ready) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (redirect_valid) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] seq_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: the next PC decode must see, plus event counts.
    logic [31:0] exp_pc = RESET_PC;
    int          cnt_hs = 0;
    int          cnt_stall = 0;
    int          cnt_flush = 0;
    int          quiet = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;

    if_fetch_stage #(
        .XLEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .seq_pc         (seq_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign seq_pc = pc + 32'd4;

    // Synchronous instruction memory: the word index doubles as the data.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr >> 2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Every instruction accepted by decode must be the next one in program
    // order from the last reset or redirect target.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
            chk("rst_pc", pc, RESET_PC);
            chk("rst_if_pc", if_pc, 32'd0);
            chk("rst_if_instr", if_instr, NOP_INSTR);
            exp_pc     = RESET_PC;
            cnt_hs     = 0;
            cnt_stall  = 0;
            cnt_flush  = 0;
            quiet      = 0;
            prev_stall = 1'b0;
        end else begin
            chk("addr_is_pc", imem_addr, pc);
            if (redirect_valid) chk("en_in_redirect", {31'd0, imem_en}, 32'd0);
            if (prev_stall) begin
                chk("hold_valid", {31'd0, if_valid}, 32'd1);
                chk("hold_pc", if_pc, prev_pc);
                chk("hold_instr", if_instr, prev_instr);
            end
            if (quiet >= 3) chk("throughput", {31'd0, if_valid}, 32'd1);
            if (if_valid && id_ready) begin
                chk("hs_pc", if_pc, exp_pc);
                chk("hs_instr", if_instr, exp_pc >> 2);
                exp_pc = exp_pc + 32'd4;
                cnt_hs++;
            end
            if (if_valid && !id_ready) cnt_stall++;
            if (redirect_valid) begin
                cnt_flush++;
                exp_pc = {redirect_pc[31:2], 2'b00};
            end
            prev_stall = if_valid && !id_ready && !redirect_valid;
            prev_pc    = if_pc;
            prev_instr = if_instr;
            quiet      = (id_ready && !redirect_valid) ? quiet + 1 : 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_pc(input logic [31:0] a);
        int n;
        n = 0;
        id_ready = 1'b1;
        while (!(if_valid && if_pc == a) && n < 80) begin
            step();
            n++;
        end
        chk("reach_pc", if_valid ? if_pc : 32'hFFFF_FFFF, a);
    endtask

    task automatic wait_valid(input logic [31:0] a);
        int n;
        n = 0;
        while (!if_valid && n < 20) begin
            step();
            n++;
        end
        chk("next_valid_pc", if_valid ? if_pc : 32'hFFFF_FFFF, a);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        step();
        step();

        // Reset release: addresses 0,4,8 and first valid two cycles later.
        rst_n = 1'b1;
        id_ready = 1'b1;
        #1;
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_en", {31'd0, imem_en}, 32'd1);
        chk("c0_valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("c1_addr", imem_addr, 32'h4);
        chk("c1_valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("c2_addr", imem_addr, 32'h8);
        chk("c2_valid", {31'd0, if_valid}, 32'd1);
        chk("c2_if_pc", if_pc, 32'h0);
        chk("c2_if_instr", if_instr, 32'h0);
        for (int i = 0; i < 4; i++) step();
        chk("c6_if_pc", if_pc, 32'h10);

        // Three stall cycles at 0x10; the skid fills and fetch stops.
        id_ready = 1'b0;
        step();
        chk("stall_pc", if_pc, 32'h10);
        chk("stall_en", {31'd0, imem_en}, 32'd0);
        step();
        chk("stall_pc2", if_pc, 32'h10);
        chk("stall_en2", {31'd0, imem_en}, 32'd0);
        step();
        id_ready = 1'b1;
        step();
        chk("after_stall_pc", if_pc, 32'h14);

        // Redirect while stalled with the skid full.
        run_until_pc(32'h20);
        id_ready = 1'b0;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("redir_en", {31'd0, imem_en}, 32'd0);
        step();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        wait_valid(32'h200);

        // Redirect to a misaligned target concurrent with a handshake at 0x40.
        redirect_valid = 1'b1;
        redirect_pc = 32'h30;
        step();
        redirect_valid = 1'b0;
        run_until_pc(32'h40);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect_valid = 1'b0;
        chk("redir_fetch_addr", imem_addr, 32'h200);
        wait_valid(32'h200);

        // Asynchronous reset mid-stall with the skid full.
        run_until_pc(32'h210);
        id_ready = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_if_pc", if_pc, 32'h0);
        chk("arst_if_instr", if_instr, NOP_INSTR);
        chk("arst_pc", pc, RESET_PC);
        step();
        rst_n = 1'b1;
        id_ready = 1'b1;
        #1;
        chk("arst_restart_addr", imem_addr, RESET_PC);
        wait_valid(RESET_PC);

`ifdef IF_PERF_CNT_EN
        // 1 redirect, 10 transfers, 3 stall cycles.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        for (int n = 0; n < 60 && cnt_hs < 5; n++) step();
        id_ready = 1'b0;
        step();
        step();
        step();
        id_ready = 1'b1;
        for (int n = 0; n < 60 && cnt_hs < 10; n++) step();
        chk("perf_fetch", perf_fetch_cnt, 32'd10);
        chk("perf_stall", perf_stall_cnt, 32'd3);
        chk("perf_flush", perf_flush_cnt, 32'd1);
`endif

        // Randomized traffic with occasional redirects and resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom_range(0, 32'h3fff);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        step();
        step();
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch_rand", perf_fetch_cnt, cnt_hs);
        chk("perf_stall_rand", perf_stall_cnt, cnt_stall);
        chk("perf_flush_rand", perf_flush_cnt, cnt_flush);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
